// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, frame constants and defaults.
package uart_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_START = 2'd1;
    localparam logic [STATE_W-1:0] ST_DATA  = 2'd2;
    localparam logic [STATE_W-1:0] ST_STOP  = 2'd3;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        STOP_LEVEL = 1'b1;

    // 50 MHz / 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
    localparam int unsigned DEFAULT_DEPTH_LOG2   = 4;

    // A completed byte waiting to enter the FIFO
    typedef struct packed {
        logic                 valid;
        logic [DATA_BITS-1:0] data;
    } rx_byte_t;

    // Serial data arrives LSB first: new bit enters at the top, older bits move down
    function automatic logic [DATA_BITS-1:0] shift_in_lsb_first(
        input logic [DATA_BITS-1:0] cur,
        input logic                 bit_in
    );
        return {bit_in, cur[DATA_BITS-1:1]};
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead circular byte FIFO with occupancy count; push into a full FIFO
// is only taken when a pop frees a slot in the same cycle.
module byte_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned DATA_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic                i_pop,
    output logic [DATA_W-1:0]   o_rdata,
    output logic                o_full,
    output logic                o_empty,
    output logic [DEPTH_LOG2:0] o_count
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic w_pop;
    logic w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive path: 8N1 deserialiser feeding a show-ahead byte FIFO read by the core.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DEPTH_LOG2   = DEFAULT_DEPTH_LOG2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    input  logic                 uart_rdreq,
    output logic                 uart_empty,
    output logic [7:0]           uart_in,
    output logic [DEPTH_LOG2:0]  rx_count,
    output logic                 framing_err,
    output logic                 overrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_rxs;
    logic [STATE_W-1:0]   r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIT_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    rx_byte_t             r_push;
    logic                 r_ferr;
    logic                 r_overrun;

    logic [STATE_W-1:0]   w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [BIT_W-1:0]     w_bit_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    rx_byte_t             w_push_nxt;
    logic                 w_ferr_nxt;
    logic                 w_full;
    logic                 w_overrun_c;

    // Two-flop synchroniser for the asynchronous serial line, idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxs   <= r_sync1;
        end
    end

    // Deserialiser state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_push    <= '0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_push    <= w_push_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    // Frame sequencing: find start edge, confirm at mid start bit, sample mid-bit thereafter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_push_nxt  = '0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!r_rxs) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                end
            end
            ST_START: begin
                if (r_cnt == HALF_CNT) begin
                    w_cnt_nxt = '0;
                    if (!r_rxs) begin
                        w_state_nxt = ST_DATA;
                        w_bit_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (r_cnt == FULL_CNT) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = shift_in_lsb_first(r_shift, r_rxs);
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + BIT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (r_cnt == FULL_CNT) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                    if (r_rxs == STOP_LEVEL) begin
                        w_push_nxt.valid = 1'b1;
                        w_push_nxt.data  = r_shift;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A completed byte is lost only when the FIFO is full and the core is not popping
    assign w_overrun_c = r_push.valid && w_full && !uart_rdreq;

    // One-cycle overrun pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_overrun_c;
        end
    end

    assign framing_err = r_ferr;
    assign overrun     = r_overrun;

    byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_push.valid),
        .i_wdata (r_push.data),
        .i_pop   (uart_rdreq),
        .o_rdata (uart_in),
        .o_full  (w_full),
        .o_empty (uart_empty),
        .o_count (rx_count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model checked every cycle,
// plus directed literal expectations.
module tb_uart_rx_fifo;

    localparam int unsigned CPB   = 8;
    localparam int unsigned DL2   = 2;
    localparam int unsigned DEPTH = 4;
    // posedges from rxd falling (driven just after edge k) to the stop-bit sample edge:
    // 2 sync + 1 idle detect + half start bit + 8 data bits + 1 stop bit
    localparam int LAT_SAMPLE = 3 + CPB / 2 + 9 * CPB;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           rxd = 1'b1;
    logic           uart_rdreq = 1'b0;
    logic           uart_empty;
    logic [7:0]     uart_in;
    logic [DL2:0]   rx_count;
    logic           framing_err;
    logic           overrun;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DEPTH_LOG2   (DL2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd),
        .uart_rdreq  (uart_rdreq),
        .uart_empty  (uart_empty),
        .uart_in     (uart_in),
        .rx_count    (rx_count),
        .framing_err (framing_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         sample_edge;
        logic [7:0] data;
        bit         good;
    } frame_t;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_fall = 0;
    int         ferr_pulses = 0;
    int         ovr_pulses = 0;
    int         first_ne_cyc = -1;
    frame_t     pend[$];
    logic [7:0] mq[$];
    bit         exp_ferr = 1'b0;
    bit         exp_ovr = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: FIFO as a queue, frames complete at a known edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            pend.delete();
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
        end else begin : model_edge
            bit         pop_ok;
            bit         push_now;
            logic [7:0] pd;
            cyc++;
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
            push_now = 1'b0;
            pd       = 8'h00;
            foreach (pend[i]) begin
                if (pend[i].sample_edge == cyc && !pend[i].good) exp_ferr = 1'b1;
                if (pend[i].sample_edge + 1 == cyc && pend[i].good) begin
                    push_now = 1'b1;
                    pd       = pend[i].data;
                end
            end
            while (pend.size() > 0 && pend[0].sample_edge + 1 <= cyc) void'(pend.pop_front());
            pop_ok = uart_rdreq && (mq.size() > 0);
            if (pop_ok) void'(mq.pop_front());
            if (push_now) begin
                if (mq.size() < DEPTH) mq.push_back(pd);
                else exp_ovr = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("uart_empty", int'(uart_empty), int'(mq.size() == 0));
        chk("uart_in", int'(uart_in), (mq.size() > 0) ? int'(mq[0]) : 0);
        chk("rx_count", int'(rx_count), mq.size());
        chk("framing_err", int'(framing_err), int'(exp_ferr));
        chk("overrun", int'(overrun), int'(exp_ovr));
        if (framing_err) ferr_pulses++;
        if (overrun) ovr_pulses++;
        if (!uart_empty && first_ne_cyc < 0) first_ne_cyc = cyc;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic bit_time();
        repeat (CPB) step();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        frame_t f;
        rxd           = 1'b0;
        last_fall     = cyc;
        f.sample_edge = cyc + LAT_SAMPLE;
        f.data        = d;
        f.good        = (stop_b == 1'b1);
        pend.push_back(f);
        bit_time();
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            bit_time();
        end
        rxd = stop_b;
        bit_time();
        rxd = 1'b1;
        repeat (2) bit_time();
    endtask

    task automatic pop_expect(input logic [7:0] exp);
        chk("pop_data", int'(uart_in), int'(exp));
        uart_rdreq = 1'b1;
        step();
        uart_rdreq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int f0;
        int o0;
        logic [7:0] partial;

        // reset values
        repeat (2) step();
        chk("rst_empty", int'(uart_empty), 1);
        chk("rst_uart_in", int'(uart_in), 0);
        chk("rst_count", int'(rx_count), 0);
        chk("rst_ferr", int'(framing_err), 0);
        chk("rst_ovr", int'(overrun), 0);
        rst_n = 1'b1;
        repeat (4) step();

        // single byte 0xA5, latency and read-out
        first_ne_cyc = -1;
        send_frame(8'hA5, 1'b1);
        chk("a5_latency", first_ne_cyc - last_fall, 80);
        chk("a5_data", int'(uart_in), 8'hA5);
        chk("a5_count", int'(rx_count), 1);
        pop_expect(8'hA5);
        chk("a5_empty_after", int'(uart_empty), 1);
        chk("a5_count_after", int'(rx_count), 0);
        chk("a5_in_after", int'(uart_in), 0);

        // read while empty is ignored
        pop_expect(8'h00);
        chk("empty_pop_count", int'(rx_count), 0);

        // start glitch of 2 cycles
        f0 = ferr_pulses;
        rxd = 1'b0;
        repeat (2) step();
        rxd = 1'b1;
        repeat (3) bit_time();
        chk("glitch_empty", int'(uart_empty), 1);
        chk("glitch_ferr", ferr_pulses - f0, 0);

        // framing error then good frame
        f0 = ferr_pulses;
        send_frame(8'h3C, 1'b0);
        chk("ferr_pulses", ferr_pulses - f0, 1);
        chk("ferr_empty", int'(uart_empty), 1);
        send_frame(8'h11, 1'b1);
        pop_expect(8'h11);

        // overrun on fifth byte
        o0 = ovr_pulses;
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        chk("ovr_count", int'(rx_count), 4);
        chk("ovr_pulses", ovr_pulses - o0, 1);
        for (int b = 1; b <= 4; b++) pop_expect(8'(b));
        chk("ovr_drained", int'(uart_empty), 1);

        // full FIFO, pop coincides with push of 0x99
        for (int b = 0; b < 4; b++) send_frame(8'h21 + 8'(b), 1'b1);
        chk("full_count", int'(rx_count), 4);
        o0 = ovr_pulses;
        fork
            send_frame(8'h99, 1'b1);
            begin
                #1;
                repeat (LAT_SAMPLE) @(posedge clk);
                #2;
                chk("full_head", int'(uart_in), 8'h21);
                uart_rdreq = 1'b1;
                step();
                uart_rdreq = 1'b0;
            end
        join
        chk("full_no_ovr", ovr_pulses - o0, 0);
        chk("full_count_after", int'(rx_count), 4);
        pop_expect(8'h22);
        pop_expect(8'h23);
        pop_expect(8'h24);
        pop_expect(8'h99);

        // reset during data bit 4 with two bytes queued
        send_frame(8'h77, 1'b1);
        send_frame(8'h88, 1'b1);
        chk("pre_rst_count", int'(rx_count), 2);
        partial = 8'hF0;
        rxd = 1'b0;
        bit_time();
        for (int i = 0; i < 4; i++) begin
            rxd = partial[i];
            bit_time();
        end
        rxd = partial[4];
        repeat (4) step();
        rst_n = 1'b0;
        rxd = 1'b1;
        #1;
        chk("mid_rst_empty", int'(uart_empty), 1);
        chk("mid_rst_count", int'(rx_count), 0);
        chk("mid_rst_in", int'(uart_in), 0);
        chk("mid_rst_ferr", int'(framing_err), 0);
        chk("mid_rst_ovr", int'(overrun), 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) bit_time();
        send_frame(8'h5A, 1'b1);
        chk("post_rst_count", int'(rx_count), 1);
        pop_expect(8'h5A);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
